// File: rtl/dvi_in_pkg.sv
// -----------------------------------------------------------------------------
// dvi_in_pkg
// Shared types and defaults for the DVI/HDMI receive-path link monitor.
//   link_state_t : supervisor FSM states
//   DEF_*        : default parameter values for the monitor and its line timer
//   ALL_ALIGNED  : ch_aligned pattern meaning all three TMDS channels aligned
//   sat_inc8     : saturating 8-bit increment used for the retry counter
// -----------------------------------------------------------------------------
package dvi_in_pkg;

  typedef enum logic [2:0] {
    WAIT_RST   = 3'd0,
    WAIT_ALIGN = 3'd1,
    VERIFY     = 3'd2,
    UP         = 3'd3,
    REQUEST    = 3'd4
  } link_state_t;

  localparam int DEF_LINE_W        = 12;
  localparam int DEF_TMO_W         = 20;
  localparam int DEF_ALIGN_TIMEOUT = 1000000;
  localparam int DEF_STABLE_LINES  = 16;
  localparam int DEF_MAX_BAD_LINES = 4;

  localparam logic [2:0] ALL_ALIGNED = 3'b111;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/dvi_in_line_timer.sv
// -----------------------------------------------------------------------------
// dvi_in_line_timer
// Measures the decoded hsync period in pclk1x cycles.
//   clk          in   pixel clock (pclk1x)
//   rst_n        in   synchronous active-low reset
//   hsync        in   decoded hsync from channel 0
//   period_valid out  one-cycle strobe on each registered hsync rising edge
//   period       out  cycles since the previous edge (counter + 1)
//   hs_timeout   out  period counter saturated, no edge seen for too long
// -----------------------------------------------------------------------------
module dvi_in_line_timer
  import dvi_in_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsync,
  output logic              period_valid,
  output logic [LINE_W-1:0] period,
  output logic              hs_timeout
);

  localparam logic [LINE_W-1:0] CNT_MAX = {LINE_W{1'b1}};
  localparam logic [LINE_W-1:0] CNT_ONE = LINE_W'(1);

  logic              hs_q,      hs_d;
  logic              hs_prev_q, hs_prev_d;
  logic [LINE_W-1:0] cnt_q,     cnt_d;
  logic              rise;

  // Edge detect on the registered hsync and next value of the period counter.
  always_comb begin
    hs_d       = hsync;
    hs_prev_d  = hs_q;
    rise       = hs_q & ~hs_prev_q;
    hs_timeout = (cnt_q == CNT_MAX);
    if (rise) begin
      cnt_d = '0;
    end else if (hs_timeout) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    // A saturated counter reports the ceiling rather than wrapping to zero.
    if (hs_timeout) begin
      period = CNT_MAX;
    end else begin
      period = cnt_q + CNT_ONE;
    end
    period_valid = rise;
  end

  // hsync sampling registers and period counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hs_q      <= hs_d;
      hs_prev_q <= hs_prev_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/dvi_in_link_monitor.sv
// -----------------------------------------------------------------------------
// dvi_in_link_monitor
// Supervises the DVI/HDMI receive path after PLL lock: waits for word
// alignment on all TMDS channels, verifies a stable hsync period, reports the
// link as up, and requests a receive-path reset when bring-up fails or the
// link is lost.
//   pclk1x      in   pixel clock
//   rst_n       in   synchronous active-low reset
//   locked      in   PLL/MMCM lock
//   in_rst      in   receive-path reset currently applied (reset controller)
//   ch_aligned  in   per-channel word-alignment done
//   hsync       in   decoded hsync, channel 0
//   rst_request out  reset request to the reset controller
//   link_up     out  link verified and stable
//   line_period out  last accepted hsync period in pclk1x cycles
//   retry_count out  saturating count of issued reset requests
// -----------------------------------------------------------------------------
module dvi_in_link_monitor
  import dvi_in_pkg::*;
#(
  parameter int LINE_W        = DEF_LINE_W,
  parameter int TMO_W         = DEF_TMO_W,
  parameter int ALIGN_TIMEOUT = DEF_ALIGN_TIMEOUT,
  parameter int STABLE_LINES  = DEF_STABLE_LINES,
  parameter int MAX_BAD_LINES = DEF_MAX_BAD_LINES
) (
  input  logic              pclk1x,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              in_rst,
  input  logic [2:0]        ch_aligned,
  input  logic              hsync,
  output logic              rst_request,
  output logic              link_up,
  output logic [LINE_W-1:0] line_period,
  output logic [7:0]        retry_count
);

  localparam int GOOD_W = $clog2(STABLE_LINES + 1);
  localparam int BAD_W  = $clog2(MAX_BAD_LINES + 1);

  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ALIGN_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_DONE = GOOD_W'(STABLE_LINES);
  localparam logic [BAD_W-1:0]  BAD_ONE   = BAD_W'(1);
  localparam logic [BAD_W-1:0]  BAD_LIMIT = BAD_W'(MAX_BAD_LINES);

  link_state_t       state_q,       state_d;
  logic [TMO_W-1:0]  tmo_q,         tmo_d;
  logic [GOOD_W-1:0] good_q,        good_d;
  logic [BAD_W-1:0]  bad_q,         bad_d;
  logic [LINE_W-1:0] ref_period_q,  ref_period_d;
  logic              ref_seen_q,    ref_seen_d;
  logic [LINE_W-1:0] line_period_q, line_period_d;
  logic              link_up_q,     link_up_d;
  logic              rst_request_q, rst_request_d;
  logic [7:0]        retry_q,       retry_d;

  logic              period_valid;
  logic [LINE_W-1:0] period;
  logic              hs_timeout;
  logic              all_aligned;
  logic              tmo_expired;
  logic [GOOD_W-1:0] good_next;
  logic [BAD_W-1:0]  bad_next;

  dvi_in_line_timer #(
    .LINE_W (LINE_W)
  ) u_line_timer (
    .clk          (pclk1x),
    .rst_n        (rst_n),
    .hsync        (hsync),
    .period_valid (period_valid),
    .period       (period),
    .hs_timeout   (hs_timeout)
  );

  // Next-state, counter and output logic of the supervisor FSM.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    good_d        = good_q;
    bad_d         = bad_q;
    ref_period_d  = ref_period_q;
    ref_seen_d    = ref_seen_q;
    line_period_d = line_period_q;
    retry_d       = retry_q;

    all_aligned = (ch_aligned == ALL_ALIGNED);
    tmo_expired = (tmo_q == TMO_LAST);
    good_next   = (period == ref_period_q) ? (good_q + GOOD_ONE) : GOOD_ONE;
    bad_next    = bad_q + BAD_ONE;

    // Lock loss overrides every state; the reset controller handles it itself.
    if (!locked) begin
      state_d = WAIT_RST;
    end else begin
      case (state_q)
        WAIT_RST: begin
          if (!in_rst) begin
            state_d = WAIT_ALIGN;
            tmo_d   = '0;
          end else begin
            state_d = WAIT_RST;
          end
        end

        WAIT_ALIGN: begin
          // Timeout is checked first so it wins over a late alignment.
          if (tmo_expired) begin
            state_d = REQUEST;
          end else if (all_aligned) begin
            state_d      = VERIFY;
            tmo_d        = '0;
            good_d       = '0;
            ref_period_d = '0;
            ref_seen_d   = 1'b0;
          end else begin
            tmo_d = tmo_q + TMO_ONE;
          end
        end

        VERIFY: begin
          if (!all_aligned || hs_timeout || tmo_expired) begin
            state_d = REQUEST;
          end else begin
            tmo_d = tmo_q + TMO_ONE;
            if (period_valid) begin
              // The first edge only anchors timing; its period predates VERIFY.
              if (!ref_seen_q) begin
                ref_seen_d = 1'b1;
              end else begin
                good_d       = good_next;
                ref_period_d = period;
                if (good_next == GOOD_DONE) begin
                  state_d       = UP;
                  line_period_d = period;
                  bad_d         = '0;
                end else begin
                  state_d = VERIFY;
                end
              end
            end else begin
              state_d = VERIFY;
            end
          end
        end

        UP: begin
          if (!all_aligned || hs_timeout) begin
            state_d = REQUEST;
          end else if (period_valid) begin
            if (period == line_period_q) begin
              bad_d = '0;
            end else begin
              bad_d = bad_next;
              if (bad_next == BAD_LIMIT) begin
                state_d = REQUEST;
              end else begin
                state_d = UP;
              end
            end
          end else begin
            state_d = UP;
          end
        end

        REQUEST: begin
          if (in_rst) begin
            state_d = WAIT_RST;
          end else begin
            state_d = REQUEST;
          end
        end

        default: begin
          state_d = WAIT_RST;
        end
      endcase
    end

    // One retry per entry into REQUEST, never while already there.
    if ((state_d == REQUEST) && (state_q != REQUEST)) begin
      retry_d = sat_inc8(retry_q);
    end else begin
      retry_d = retry_q;
    end

    link_up_d     = (state_d == UP);
    rst_request_d = (state_d == REQUEST);
  end

  // State, counters and registered outputs.
  always_ff @(posedge pclk1x) begin
    if (!rst_n) begin
      state_q       <= WAIT_RST;
      tmo_q         <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      ref_period_q  <= '0;
      ref_seen_q    <= 1'b0;
      line_period_q <= '0;
      link_up_q     <= 1'b0;
      rst_request_q <= 1'b0;
      retry_q       <= 8'd0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      ref_period_q  <= ref_period_d;
      ref_seen_q    <= ref_seen_d;
      line_period_q <= line_period_d;
      link_up_q     <= link_up_d;
      rst_request_q <= rst_request_d;
      retry_q       <= retry_d;
    end
  end

  assign rst_request = rst_request_q;
  assign link_up     = link_up_q;
  assign line_period = line_period_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_dvi_in_link_monitor.sv
// -----------------------------------------------------------------------------
// tb_dvi_in_link_monitor
// Directed bench for dvi_in_link_monitor. A behavioural model tracks hsync
// edges by timestamp and walks the link rules; a compare process checks every
// output on every falling edge, and literal checks pin key scenario results.
// ALIGN_TIMEOUT is 600 so that a 100-cycle line can finish its five-edge
// verification before the verify watchdog expires.
// -----------------------------------------------------------------------------
module tb_dvi_in_link_monitor;

  localparam int LW  = 8;
  localparam int TW  = 20;
  localparam int AT  = 600;
  localparam int SL  = 4;
  localparam int MB  = 2;
  localparam int SAT = (1 << LW) - 1;

  localparam int S_WRST = 0;
  localparam int S_WAL  = 1;
  localparam int S_VER  = 2;
  localparam int S_UP   = 3;
  localparam int S_REQ  = 4;

  logic          pclk1x = 1'b0;
  logic          rst_n;
  logic          locked;
  logic          in_rst;
  logic [2:0]    ch_aligned;
  logic          hsync;
  logic          rst_request;
  logic          link_up;
  logic [LW-1:0] line_period;
  logic [7:0]    retry_count;

  dvi_in_link_monitor #(
    .LINE_W        (LW),
    .TMO_W         (TW),
    .ALIGN_TIMEOUT (AT),
    .STABLE_LINES  (SL),
    .MAX_BAD_LINES (MB)
  ) dut (
    .pclk1x      (pclk1x),
    .rst_n       (rst_n),
    .locked      (locked),
    .in_rst      (in_rst),
    .ch_aligned  (ch_aligned),
    .hsync       (hsync),
    .rst_request (rst_request),
    .link_up     (link_up),
    .line_period (line_period),
    .retry_count (retry_count)
  );

  always #5 pclk1x = ~pclk1x;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // hsync generator: one-cycle pulses, spacing hs_cur, optional one-off lines
  int hs_nom = 0;
  int hs_cnt = 0;
  int hs_cur = 0;
  int hs_lines[$];

  // model state
  int m_n = 0;
  int last_k = 0;
  bit pend = 1'b0;
  bit prev_h = 1'b0;
  int ms = S_WRST;
  int m_tmo = 0, m_good = 0, m_stored = 0, m_bad = 0, m_lp = 0, m_rc = 0;
  bit m_ref = 1'b0;
  int e_lu = 0, e_rr = 0, e_lp = 0, e_rc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Applies the link rules to the inputs sampled at this rising edge.
  task automatic model_step();
    bit valid;
    bit tmo_ev;
    int per;
    int nxt;
    bit aligned;
    m_n++;
    if (!rst_n) begin
      ms = S_WRST; m_tmo = 0; m_good = 0; m_stored = 0; m_bad = 0;
      m_lp = 0; m_rc = 0; m_ref = 1'b0;
      last_k = m_n - 1; pend = 1'b0; prev_h = 1'b0;
      e_lu = 0; e_rr = 0; e_lp = 0; e_rc = 0;
      return;
    end
    // hsync edge seen one sample ago becomes a period now; silence of more
    // than the counter range is a timeout
    valid  = pend;
    tmo_ev = (m_n - last_k) >= (SAT + 2);
    per    = m_n - 1 - last_k;
    if (per > SAT) per = SAT;
    if (valid) last_k = m_n - 1;
    pend   = hsync && !prev_h;
    prev_h = hsync;

    aligned = (ch_aligned == 3'b111);
    nxt = ms;
    if (!locked) begin
      nxt = S_WRST;
    end else begin
      case (ms)
        S_WRST: if (!in_rst) begin nxt = S_WAL; m_tmo = 0; end
        S_WAL: begin
          if (m_tmo == AT - 1) nxt = S_REQ;
          else if (aligned) begin
            nxt = S_VER; m_tmo = 0; m_good = 0; m_stored = 0; m_ref = 1'b0;
          end else m_tmo++;
        end
        S_VER: begin
          if (!aligned || tmo_ev || m_tmo == AT - 1) nxt = S_REQ;
          else begin
            m_tmo++;
            if (valid) begin
              if (!m_ref) m_ref = 1'b1;
              else begin
                m_good   = (per == m_stored) ? m_good + 1 : 1;
                m_stored = per;
                if (m_good == SL) begin nxt = S_UP; m_lp = per; m_bad = 0; end
              end
            end
          end
        end
        S_UP: begin
          if (!aligned || tmo_ev) nxt = S_REQ;
          else if (valid) begin
            if (per == m_lp) m_bad = 0;
            else begin
              m_bad++;
              if (m_bad == MB) nxt = S_REQ;
            end
          end
        end
        S_REQ: if (in_rst) nxt = S_WRST;
        default: nxt = S_WRST;
      endcase
    end
    if (nxt == S_REQ && ms != S_REQ && m_rc < 255) m_rc++;
    ms   = nxt;
    e_lu = (ms == S_UP) ? 1 : 0;
    e_rr = (ms == S_REQ) ? 1 : 0;
    e_lp = m_lp;
    e_rc = m_rc;
  endtask

  task automatic drive_hsync();
    if (hs_nom == 0) begin
      hsync = 1'b0;
    end else begin
      hs_cnt++;
      if (hs_cnt >= hs_cur) begin
        hsync  = 1'b1;
        hs_cnt = 0;
        hs_cur = (hs_lines.size() > 0) ? hs_lines.pop_front() : hs_nom;
      end else begin
        hsync = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge pclk1x);
    model_step();
    #1;
    drive_hsync();
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic start_hsync(input int p);
    hs_nom = p; hs_cnt = 0; hs_cur = p;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge pclk1x) begin
    if (chk_en) begin
      check("cyc_link_up",     {31'd0, link_up},     e_lu);
      check("cyc_rst_request", {31'd0, rst_request}, e_rr);
      check("cyc_line_period", {24'd0, line_period}, e_lp);
      check("cyc_retry_count", {24'd0, retry_count}, e_rc);
    end
  end

  initial begin
    rst_n = 1'b0; locked = 1'b0; in_rst = 1'b1; ch_aligned = 3'b000; hsync = 1'b0;
    run(3);
    chk_en = 1'b1;
    check("reset_link_up",     {31'd0, link_up},     0);
    check("reset_rst_request", {31'd0, rst_request}, 0);
    check("reset_line_period", {24'd0, line_period}, 0);
    check("reset_retry_count", {24'd0, retry_count}, 0);

    // nominal bring-up at a 100-cycle line
    rst_n = 1'b1; locked = 1'b1; start_hsync(100);
    run(5);
    in_rst = 1'b0; ch_aligned = 3'b111;
    run(700);
    check("nom_link_up",     {31'd0, link_up},     1);
    check("nom_line_period", {24'd0, line_period}, 100);
    check("nom_retry_count", {24'd0, retry_count}, 0);

    // single short line is tolerated
    hs_lines.push_back(99);
    run(400);
    check("glitch1_link_up", {31'd0, link_up}, 1);

    // two consecutive short lines trigger a request, held while in_rst=0
    hs_lines.push_back(99); hs_lines.push_back(99);
    run(400);
    check("glitch2_link_up", {31'd0, link_up},     0);
    check("glitch2_request", {31'd0, rst_request}, 1);
    check("glitch2_retry",   {24'd0, retry_count}, 1);
    in_rst = 1'b1;
    run(2);
    check("glitch2_release", {31'd0, rst_request}, 0);
    in_rst = 1'b0;
    run(700);
    check("rebring_link_up", {31'd0, link_up}, 1);

    // lock loss in UP drops link_up without a request
    locked = 1'b0;
    run(1);
    check("lock_link_up", {31'd0, link_up},     0);
    check("lock_request", {31'd0, rst_request}, 0);
    check("lock_retry",   {24'd0, retry_count}, 1);
    locked = 1'b1;
    run(700);
    check("relock_link_up", {31'd0, link_up}, 1);

    // hsync loss in UP
    hs_nom = 0;
    run(300);
    check("hsloss_link_up", {31'd0, link_up},     0);
    check("hsloss_request", {31'd0, rst_request}, 1);
    check("hsloss_retry",   {24'd0, retry_count}, 2);

    // synchronous reset in the middle of REQUEST
    rst_n = 1'b0; in_rst = 1'b1; ch_aligned = 3'b011;
    run(1);
    check("midreq_link_up",     {31'd0, link_up},     0);
    check("midreq_rst_request", {31'd0, rst_request}, 0);
    check("midreq_line_period", {24'd0, line_period}, 0);
    check("midreq_retry_count", {24'd0, retry_count}, 0);

    // alignment timeout: request issued on the ALIGN_TIMEOUT-th aligning cycle
    rst_n = 1'b1;
    run(3);
    in_rst = 1'b0;
    run(AT);
    check("align_before_tmo", {31'd0, rst_request}, 0);
    run(1);
    check("align_at_tmo",     {31'd0, rst_request}, 1);
    check("align_retry",      {24'd0, retry_count}, 1);
    run(5);
    check("align_held",       {31'd0, rst_request}, 1);
    in_rst = 1'b1;
    run(1);
    check("align_release",    {31'd0, rst_request}, 0);

    // 150-cycle lines cannot finish verification inside the watchdog
    start_hsync(150); ch_aligned = 3'b111;
    run(200);
    in_rst = 1'b0;
    run(900);
    check("vtmo_link_up", {31'd0, link_up},     0);
    check("vtmo_request", {31'd0, rst_request}, 1);
    check("vtmo_retry",   {24'd0, retry_count}, 2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
